// File: rtl/rgb_fade_cfg_if.sv
// Keyframe configuration bus for the RGB fade sequencer.
// A write lands when cfg_valid and cfg_ready are both high on a clock edge.
interface rgb_fade_cfg_if #(
  parameter int DUTY_W = 32,
  parameter int IDX_W  = 2
);
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [IDX_W-1:0]         cfg_idx;
  logic signed [DUTY_W-1:0] cfg_red;
  logic signed [DUTY_W-1:0] cfg_green;
  logic signed [DUTY_W-1:0] cfg_blue;

  modport master (
    output cfg_valid, cfg_idx, cfg_red, cfg_green, cfg_blue,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_idx, cfg_red, cfg_green, cfg_blue,
    output cfg_ready
  );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// Keyframe colour sequencer: fades the three PWM borders one count per step
// toward each keyframe, holds there, then advances, looping until stopped.
module rgb_fade_sequencer #(
  parameter int DUTY_W      = 32,
  parameter int DUTY_MAX    = 1000,
  parameter int NUM_KEYS    = 4,
  parameter int STEP_DIV    = 100,
  parameter int HOLD_CYCLES = 100000,
  localparam int IDX_W      = $clog2(NUM_KEYS)
) (
  input  logic                     clk,
  input  logic                     reset,
  rgb_fade_cfg_if.slave            cfg,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic [IDX_W-1:0]         key_idx,
  output logic                     loop_pulse,
  output logic signed [DUTY_W-1:0] red_border,
  output logic signed [DUTY_W-1:0] green_border,
  output logic signed [DUTY_W-1:0] blue_border
);
  localparam int STEP_W = $clog2(STEP_DIV + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  KEY_LAST  = IDX_W'(NUM_KEYS - 1);
  localparam logic signed [DUTY_W-1:0] DMAX = DUTY_W'(DUTY_MAX);
  localparam logic signed [DUTY_W-1:0] ONE  = DUTY_W'(1);

  typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [STEP_W-1:0]        step_cnt_q, step_cnt_d;
  logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]         key_idx_q, key_idx_d;
  logic                     loop_pulse_q, loop_pulse_d;
  logic signed [DUTY_W-1:0] border_q [3];
  logic signed [DUTY_W-1:0] border_d [3];
  logic signed [DUTY_W-1:0] table_q [NUM_KEYS][3];
  logic signed [DUTY_W-1:0] table_d [NUM_KEYS][3];

  logic signed [DUTY_W-1:0] wr_val [3];
  logic signed [DUTY_W-1:0] target [3];
  logic signed [DUTY_W-1:0] adv [3];
  logic [2:0]               chan_eq;
  logic                     step_now, all_eq, hold_done, cfg_ready, wr_en;

  function automatic logic signed [DUTY_W-1:0] clamp(input logic signed [DUTY_W-1:0] v);
    if (v < 0)         return '0;
    else if (v > DMAX) return DMAX;
    else               return v;
  endfunction

  always_comb begin
    wr_val[0] = clamp(cfg.cfg_red);
    wr_val[1] = clamp(cfg.cfg_green);
    wr_val[2] = clamp(cfg.cfg_blue);
  end

  assign step_now  = (step_cnt_q == STEP_LAST);
  assign hold_done = (hold_cnt_q == HOLD_LAST);
  assign wr_en     = cfg.cfg_valid && cfg_ready;

  // adv is where each channel will sit after this edge if we stay in FADE;
  // HOLD is entered on the same edge the last channel lands on its target.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    always_comb begin
      target[gi] = table_q[key_idx_q][gi];
      adv[gi]    = border_q[gi];
      if (step_now) begin
        if (border_q[gi] < target[gi])      adv[gi] = border_q[gi] + ONE;
        else if (border_q[gi] > target[gi]) adv[gi] = border_q[gi] - ONE;
      end
      chan_eq[gi] = (adv[gi] == target[gi]);
    end
  end

  assign all_eq = &chan_eq;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !stop) state_d = FADE;
      FADE: if (stop) state_d = IDLE; else if (all_eq) state_d = HOLD;
      HOLD: if (stop) state_d = IDLE; else if (hold_done) state_d = FADE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    cfg_ready = (state_q == IDLE);
  end

  always_comb begin
    step_cnt_d   = step_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    key_idx_d    = key_idx_q;
    loop_pulse_d = 1'b0;
    border_d     = border_q;
    table_d      = table_q;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          for (int c = 0; c < 3; c++) table_d[cfg.cfg_idx][c] = wr_val[c];
        end
        if (start && !stop) begin
          key_idx_d  = '0;
          step_cnt_d = '0;
        end
      end
      FADE: begin
        if (!stop) begin
          border_d   = adv;
          step_cnt_d = step_now ? '0 : step_cnt_q + STEP_W'(1);
          if (all_eq) hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (!stop) begin
          if (hold_done) begin
            key_idx_d    = key_idx_q + IDX_W'(1);
            loop_pulse_d = (key_idx_q == KEY_LAST);
            step_cnt_d   = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      key_idx_q    <= '0;
      loop_pulse_q <= 1'b0;
      for (int c = 0; c < 3; c++) border_q[c] <= '0;
      for (int k = 0; k < NUM_KEYS; k++)
        for (int c = 0; c < 3; c++) table_q[k][c] <= '0;
    end else begin
      step_cnt_q   <= step_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      key_idx_q    <= key_idx_d;
      loop_pulse_q <= loop_pulse_d;
      border_q     <= border_d;
      table_q      <= table_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready;
  assign key_idx       = key_idx_q;
  assign loop_pulse    = loop_pulse_q;
  assign red_border    = border_q[0];
  assign green_border  = border_q[1];
  assign blue_border   = border_q[2];
endmodule
